rom_fetch: RTL and testbench

- Instruction-fetch initiator for the core. Drives the word-addressed ROM-Flash read port (region 0x080x_xxxx) and prefetches sequential words into a small FIFO.
- Hands words to the decoder over a valid/ready handshake.
- Supports branch redirect with flush and discards stale in-flight responses.
- Sits between the ROM-Flash and the decode stage. Never writes the ROM.

---
 rtl/rom_fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/rom_fetch.sv | 117 +++++++++++
 tb/tb_rom_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_pkg.sv
// Shared constants and bundle types for the ROM-Flash instruction fetcher.
// Region tag, address bounds and the fetch-entry record live here.
package rom_fetch_pkg;

  localparam logic [31:0] ROM_BASE = 32'h0800_0000;
  localparam logic [31:0] ROM_LAST = 32'h080F_FFFF;
  localparam logic [11:0] ROM_REGION_TAG = 12'h080;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic in_rom(
    input logic [31:0] addr
  );
    return addr[31:20] == ROM_REGION_TAG;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between the ROM response path and decode.
// Synchronous FIFO with flush; head is zero while empty.
module fetch_fifo
  import rom_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic [CW-1:0] count,
  output logic         head_valid,
  output fetch_entry_t head_entry
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Qualify push/pop; a full FIFO accepts a push only alongside a pop.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL_CNT) || do_pop);
    head_valid = (count != '0);
    head_entry = head_valid ? mem[rd_ptr] : '0;
  end

  // Pointer and occupancy bookkeeping; flush empties in one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: count <= count + 1'b1;
        do_pop && !do_push: count <= count - 1'b1;
        default:            count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/rom_fetch.sv
// Instruction-fetch initiator: streams sequential ROM words into a
// prefetch FIFO, with redirect/flush and stale-response discard.
module rom_fetch
  import rom_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ROM_BASE,
  parameter int          DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] mem_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [31:0]   pc;
  logic          epoch;
  logic          inflight;
  logic [31:0]   tag_pc;
  logic          tag_epoch;
  logic          fault;
  logic [31:0]   addr_q;

  logic [CW-1:0] fifo_count;
  logic          head_valid;
  fetch_entry_t  head_entry;
  fetch_entry_t  rsp_entry;
  logic [CW:0]   used;
  logic          credit_ok;
  logic          pc_ok;
  logic          issue;
  logic          raise_fault;
  logic          rsp_push;
  logic          pop;

  // Issue/credit decisions; the in-flight slot reserves a FIFO entry.
  always_comb begin
    used        = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    credit_ok   = used < CREDITS;
    pc_ok       = in_rom(pc);
    issue       = !fault && !redirect_valid && credit_ok && pc_ok;
    raise_fault = !fault && !redirect_valid && !pc_ok;
    rsp_push    = inflight && (tag_epoch == epoch) && !redirect_valid;
    pop         = head_valid && instr_ready && !redirect_valid;
    rsp_entry   = '{data: mem_data_in, pc: tag_pc};
  end

  // Bus request register and the tag of the word now on the bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= RESET_PC;
      inflight  <= 1'b0;
      tag_pc    <= '0;
      tag_epoch <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        addr_q    <= pc;
        tag_pc    <= pc;
        tag_epoch <= epoch;
      end
    end
  end

  // Fetch pc, epoch and sticky region fault; redirect wins over all.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= RESET_PC;
      epoch <= 1'b0;
      fault <= 1'b0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      epoch <= ~epoch;
      fault <= 1'b0;
    end else begin
      if (issue)       pc <= pc + 32'd1;
      if (raise_fault) fault <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_entry(rsp_entry),
    .pop       (pop),
    .count     (fifo_count),
    .head_valid(head_valid),
    .head_entry(head_entry)
  );

  // Read-only initiator: write side of the bus is tied off.
  always_comb begin
    mem_address      = addr_q;
    mem_write_enable = 1'b0;
    mem_data_out     = '0;
    instr_valid      = head_valid;
    instr_data       = head_entry.data;
    instr_pc         = head_entry.pc;
    fetch_fault      = fault;
  end

endmodule

// File: tb/tb_rom_fetch.sv
// Scoreboard bench for rom_fetch: expected word stream per redirect,
// checked by an independent monitor on the falling edge.
module tb_rom_fetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_q[$];

  always #5 clock = ~clock;

  rom_fetch #(
    .RESET_PC(32'h0800_0000),
    .DEPTH   (4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .mem_address     (mem_address),
    .mem_write_enable(mem_write_enable),
    .mem_data_out    (mem_data_out),
    .mem_data_in     (mem_data_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .fetch_fault     (fetch_fault)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + (a - 32'h0800_0000);
  endfunction

  assign mem_data_in = rom_word(mem_address);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected delivery order after a restart at start: sequential words
  // until the pc leaves the ROM region.
  task automatic load_q(input logic [31:0] start);
    logic [31:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 160; i++) begin
      if (p[31:20] != 12'h080) break;
      exp_q.push_back({p, rom_word(p)});
      p = p + 32'd1;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    load_q(target);
    step();
    redirect_valid = 1'b0;
    redirect_pc = $urandom;
  endtask

  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [31:0] hold_p;

  always @(negedge clock) begin
    logic [63:0] e;
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      check("mem_write_enable", {31'b0, mem_write_enable}, 32'd0);
      check("mem_data_out", mem_data_out, 32'd0);
      if (hold_v) begin
        check("hold_valid", {31'b0, instr_valid}, 32'd1);
        check("hold_data", instr_data, hold_d);
        check("hold_pc", instr_pc, hold_p);
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got pc %h data %h want none",
                   instr_pc, instr_data);
        end else begin
          e = exp_q.pop_front();
          check("word_pc", instr_pc, e[63:32]);
          check("word_data", instr_data, e[31:0]);
        end
      end
      hold_v = instr_valid && !instr_ready && !redirect_valid;
      hold_d = instr_data;
      hold_p = instr_pc;
    end
  end

  initial begin
    int gaps;
    int since;
    int r;
    logic [31:0] t;

    reset_n = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    repeat (2) step();
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_data", instr_data, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_addr", mem_address, 32'h0800_0000);

    load_q(32'h0800_0000);
    reset_n = 1'b1;
    step();
    check("boot_valid0", {31'b0, instr_valid}, 32'd0);
    check("boot_addr0", mem_address, 32'h0800_0000);
    step();
    check("boot_valid1", {31'b0, instr_valid}, 32'd1);
    check("boot_pc", instr_pc, 32'h0800_0000);
    check("boot_data", instr_data, 32'hA000_0000);
    check("boot_addr1", mem_address, 32'h0800_0001);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stream_addr", mem_address, 32'h0800_0002 + i);
      check("stream_valid", {31'b0, instr_valid}, 32'd1);
    end

    reset_n = 1'b0;
    exp_q.delete();
    step();
    instr_ready = 1'b0;
    load_q(32'h0800_0000);
    reset_n = 1'b1;
    repeat (10) step();
    check("stall_addr", mem_address, 32'h0800_0003);
    check("stall_valid", {31'b0, instr_valid}, 32'd1);
    check("stall_pc", instr_pc, 32'h0800_0000);
    instr_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 12; i++) begin
      if (!instr_valid) gaps++;
      step();
    end
    check("drain_gaps", gaps, 32'd0);

    instr_ready = 1'b0;
    step();
    instr_ready = 1'b1;
    do_redirect(32'h0800_0100);
    check("redir_valid_r", {31'b0, instr_valid}, 32'd0);
    step();
    check("redir_valid_r1", {31'b0, instr_valid}, 32'd0);
    step();
    check("redir_valid_r2", {31'b0, instr_valid}, 32'd1);
    check("redir_pc", instr_pc, 32'h0800_0100);
    check("redir_data", instr_data, 32'hA000_0100);

    repeat (5) step();
    do_redirect(32'h0800_0000);
    check("rpp_valid_r", {31'b0, instr_valid}, 32'd0);
    step();
    check("rpp_valid_r1", {31'b0, instr_valid}, 32'd0);
    check("rpp_addr", mem_address, 32'h0800_0000);
    step();
    check("rpp_pc", instr_pc, 32'h0800_0000);

    do_redirect(32'h080F_FFFE);
    for (int i = 0; i < 10; i++) begin
      if (fetch_fault) break;
      step();
    end
    check("end_fault", {31'b0, fetch_fault}, 32'd1);
    repeat (3) step();
    check("end_addr", mem_address, 32'h080F_FFFF);
    check("end_valid", {31'b0, instr_valid}, 32'd0);
    check("end_left", exp_q.size(), 32'd0);
    do_redirect(32'h0800_0000);
    check("clr_fault", {31'b0, fetch_fault}, 32'd0);
    step();
    step();
    check("resume_valid", {31'b0, instr_valid}, 32'd1);
    check("resume_pc", instr_pc, 32'h0800_0000);

    repeat (3) step();
    instr_ready = 1'b0;
    step();
    step();
    check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_pc", instr_pc, 32'd0);
    step();
    load_q(32'h0800_0000);
    instr_ready = 1'b1;
    reset_n = 1'b1;
    step();
    check("rrst_addr", mem_address, 32'h0800_0000);
    check("rrst_valid0", {31'b0, instr_valid}, 32'd0);
    step();
    check("rrst_valid1", {31'b0, instr_valid}, 32'd1);
    check("rrst_pc", instr_pc, 32'h0800_0000);

    since = 0;
    for (int c = 0; c < 800; c++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      if (since > 100 || $urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 6)      t = 32'h0800_0000 + $urandom_range(0, 4095);
        else if (r < 9) t = 32'h080F_FFFF - $urandom_range(0, 5);
        else            t = 32'h2000_0000 + $urandom_range(0, 4095);
        do_redirect(t);
        since = 0;
      end else begin
        step();
        since++;
      end
    end

    instr_ready = 1'b1;
    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
